// File: rtl/accum_drain.sv
// accum_drain: sweeps a wrap-around range of accumulator rows, requantizes each
// 32-bit signed partial sum to a narrow signed word (round, shift, saturate)
// and streams the results out through a credit-limited FIFO.
// Optional feature: define ACCUM_DRAIN_RELU_EN to clamp negative sums to 0.
module accum_drain #(
  parameter int ACCUM_ROW  = 256,
  parameter int ADDR_WIDTH = $clog2(ACCUM_ROW),
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH:0]           num_rows,
  input  logic [$clog2(DATA_WIDTH)-1:0] shift,
  output logic                          busy,
  output logic                          done,
  output logic                          acc_rd_en,
  output logic [ADDR_WIDTH-1:0]         acc_rd_addr,
  input  logic [DATA_WIDTH-1:0]         acc_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_last
);

  localparam int SHIFT_W = $clog2(DATA_WIDTH);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ROWS_W  = ADDR_WIDTH + 1;

  localparam logic signed [DATA_WIDTH:0] SAT_HI = (DATA_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [DATA_WIDTH:0] SAT_LO = (DATA_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ROWS_W-1:0]     rem;
  logic [SHIFT_W-1:0]    shift_r;
  logic                  pending;
  logic                  pending_last;
  logic                  rd_en;
  logic                  rem_is_one;
  logic [ROWS_W-1:0]     rows_clamped;
  logic                  credit_ok;

  logic [OUT_WIDTH-1:0]  data_mem [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  head_last;

  logic signed [DATA_WIDTH:0] q_ext;
  logic signed [DATA_WIDTH:0] q_bias;
  logic signed [DATA_WIDTH:0] q_sum;
  logic signed [DATA_WIDTH:0] q_shr;
  logic [OUT_WIDTH-1:0]       q_word;

  assign rows_clamped = (num_rows > ROWS_W'(ACCUM_ROW)) ? ROWS_W'(ACCUM_ROW) : num_rows;
  assign rem_is_one   = (rem == ROWS_W'(1));
  // A read is only issued if its data is guaranteed a FIFO slot, counting the
  // read still in flight from the previous cycle.
  assign credit_ok    = (CNT_W'(pending) + count) < CNT_W'(FIFO_DEPTH);

  assign fifo_push = pending;
  assign out_valid = (count != '0);
  assign fifo_pop  = out_valid && out_ready;
  assign head_last = last_mem[rd_ptr];
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_last  = out_valid ? last_mem[rd_ptr] : 1'b0;

  assign acc_rd_en   = rd_en;
  assign acc_rd_addr = addr;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and read strobe.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (rows_clamped == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (rem_is_one) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // Leaving on the final handshake itself puts done one cycle after it.
        if (!pending && fifo_pop && head_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command registers, sweep address/count and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      rem          <= '0;
      shift_r      <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      pending      <= rd_en;
      pending_last <= rd_en && rem_is_one;
      if (state == IDLE && start) begin
        addr    <= base_addr;
        rem     <= rows_clamped;
        shift_r <= shift;
      end else if (rd_en) begin
        addr <= (addr == ADDR_WIDTH'(ACCUM_ROW - 1)) ? '0 : addr + ADDR_WIDTH'(1);
        rem  <= rem - ROWS_W'(1);
      end
    end
  end

  // Requantize returning data: extend, round, arithmetic shift, saturate.
  always_comb begin
    q_ext = {acc_rd_data[DATA_WIDTH-1], acc_rd_data};
`ifdef ACCUM_DRAIN_RELU_EN
    if (acc_rd_data[DATA_WIDTH-1]) q_ext = '0;
`endif
    q_bias = '0;
    if (shift_r != '0) q_bias = (DATA_WIDTH+1)'(1) << (shift_r - SHIFT_W'(1));
    q_sum = q_ext + q_bias;
    q_shr = q_sum >>> shift_r;
    if (q_shr > SAT_HI)      q_word = SAT_HI[OUT_WIDTH-1:0];
    else if (q_shr < SAT_LO) q_word = SAT_LO[OUT_WIDTH-1:0];
    else                     q_word = q_shr[OUT_WIDTH-1:0];
  end

  // FIFO storage; contents need no reset since reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      data_mem[wr_ptr] <= q_word;
      last_mem[wr_ptr] <= pending_last;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_drain.sv
// tb_accum_drain: scoreboard bench for accum_drain with a 1-cycle-latency
// accumulator memory model and a stream monitor.
module tb_accum_drain;

  localparam int ACCUM_ROW  = 256;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int OUT_WIDTH  = 8;
  localparam int FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   num_rows;
  logic [4:0]            shift;
  logic                  busy, done, acc_rd_en;
  logic [ADDR_WIDTH-1:0] acc_rd_addr;
  logic [DATA_WIDTH-1:0] acc_rd_data = '0;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_last;

  accum_drain #(
    .ACCUM_ROW (ACCUM_ROW),
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .shift      (shift),
    .busy       (busy),
    .done       (done),
    .acc_rd_en  (acc_rd_en),
    .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] mem [ACCUM_ROW];
  int     exp_addr [$];
  longint exp_data [$];
  bit     exp_last [$];

  int     outstanding = 0;
  bit     expect_hs = 0;
  int     last_hs_cyc = -100;
  bit     rand_ready = 0;
  bit     prev_stall = 0;
  longint prev_data = 0;
  bit     prev_last = 0;
  bit     mdl_en = 0;
  logic [ADDR_WIDTH-1:0] mdl_addr = '0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint quant(input logic [31:0] acc, input int sh);
    longint v;
    v = longint'($signed(acc));
`ifdef ACCUM_DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Accumulator model: data for a read sampled in cycle c is valid in cycle c+1.
  always @(negedge clk) begin
    mdl_en   = acc_rd_en;
    mdl_addr = acc_rd_addr;
  end
  always @(posedge clk) begin
    #1;
    acc_rd_data = mdl_en ? mem[mdl_addr] : '0;
  end

  // Randomized consumer readiness when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Stream monitor and scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", longint'($signed(out_data)), prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (acc_rd_en) begin
        check("extra_read", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) check("rd_addr", acc_rd_addr, exp_addr.pop_front());
        outstanding++;
        check("credit", outstanding <= FIFO_DEPTH, 1);
      end
      if (out_valid && out_ready) begin
        outstanding--;
        check("extra_word", exp_data.size() > 0, 1);
        if (exp_data.size() > 0) begin
          check("out_data", longint'($signed(out_data)), exp_data.pop_front());
          check("out_last", out_last, exp_last.pop_front());
        end
        if (out_last) last_hs_cyc = cyc;
      end
      if (done) begin
        check("done_drained", exp_data.size(), 0);
        if (expect_hs) check("done_latency", cyc, last_hs_cyc + 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = longint'($signed(out_data));
      prev_last  = out_last;
    end
  end

  // Push expectations, then strobe start for one cycle; returns in cycle 1.
  task automatic go(input int base, input int n, input int sh);
    int nc;
    nc = (n > ACCUM_ROW) ? ACCUM_ROW : n;
    for (int i = 0; i < nc; i++) begin
      int a;
      a = (base + i) % ACCUM_ROW;
      exp_addr.push_back(a);
      exp_data.push_back(quant(mem[a], sh));
      exp_last.push_back(i == nc - 1);
    end
    expect_hs = (nc != 0);
    start     = 1'b1;
    base_addr = ADDR_WIDTH'(base);
    num_rows  = (ADDR_WIDTH+1)'(n);
    shift     = 5'(sh);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (!done && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("done_seen", done, 1);
    @(posedge clk);
    #1;
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; shift = '0; out_ready = 1'b1;
    for (int i = 0; i < ACCUM_ROW; i++) mem[i] = $urandom;

    // Reset values
    @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", acc_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_addr", acc_rd_addr, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;

    // Basic drain with start-latency checks
    mem[0] = 32'd100; mem[1] = -32'sd100; mem[2] = 32'd1000; mem[3] = 32'd7;
    go(0, 4, 2);
    check("lat_rd_en_c1", acc_rd_en, 1);
    check("lat_valid_c1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid_c2", out_valid, 0);
    @(posedge clk); #1;
    check("lat_valid_c3", out_valid, 1);
    wait_done(50);

    // Wrap-around
    go(254, 4, 1);
    wait_done(50);

    // Backpressure
    go(10, 12, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("bp_outstanding", outstanding, FIFO_DEPTH);
    check("bp_rd_stalled", acc_rd_en, 0);
    check("bp_valid_held", out_valid, 1);
    out_ready = 1'b1;
    wait_done(100);

    // Zero-row command
    go(5, 0, 0);
    check("zero_done_c1", done, 1);
    check("zero_busy_c1", busy, 1);
    check("zero_rd_en", acc_rd_en, 0);
    check("zero_valid", out_valid, 0);
    @(posedge clk); #1;
    check("zero_done_c2", done, 0);
    check("zero_idle_c2", busy, 0);

    // start while busy is ignored
    go(30, 8, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'd200; num_rows = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    repeat (4) begin @(posedge clk); #1; end
    check("ignored_start_idle", busy, 0);

    // Reset mid-operation
    go(60, 16, 1);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_addr.delete(); exp_data.delete(); exp_last.delete();
    outstanding = 0;
    expect_hs = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", acc_rd_en, 0);
    go(60, 16, 1);
    wait_done(100);

    // num_rows beyond ACCUM_ROW clamps to a full sweep
    go(100, 300, 4);
    wait_done(1000);

    // ReLU / saturation corner values
    mem[50] = -32'sd5; mem[51] = 32'h7FFF_FFFF; mem[52] = 32'h8000_0000;
    go(50, 3, 0);
    wait_done(50);

    // Random commands under random backpressure
    rand_ready = 1;
    for (int t = 0; t < 4; t++) begin
      go(int'($urandom_range(0, ACCUM_ROW - 1)), int'($urandom_range(1, 20)), int'($urandom_range(0, 31)));
      wait_done(500);
    end
    rand_ready = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
